channel_tester_core: RTL and testbench

- Self-contained two-lane serial link tester: each lane serializes a framed test pattern onto a 1-bit differential TX pair and deserializes, aligns and checks the matching RX pair.
- Intended for external or bench loopback (tx→rx per lane).
- Reports per-lane link status (channel_up_0/1) and a saturating error count for lane 0.
- Lightweight stand-in for a transceiver channel tester; no vendor IP.

---
 rtl/channel_tester_core_if.sv | 18 +
 rtl/channel_tester_core.sv | 152 +++++++++++++++
 tb/tb_channel_tester_core.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/channel_tester_core_if.sv
// Serial pairs and status for the two-lane link tester; the core uses slave, the harness master.
// Combinational bundle: no latency and no backpressure (free-running serial link).
interface channel_tester_core_if;
    logic       rxp_0, rxn_0, rxp_1, rxn_1;
    logic       txp_0, txn_0, txp_1, txn_1;
    logic       channel_up_0, channel_up_1;
    logic [3:0] Error_Counter_0;

    modport slave (
        input  rxp_0, rxn_0, rxp_1, rxn_1,
        output txp_0, txn_0, txp_1, txn_1, channel_up_0, channel_up_1, Error_Counter_0
    );

    modport master (
        output rxp_0, rxn_0, rxp_1, rxn_1,
        input  txp_0, txn_0, txp_1, txn_1, channel_up_0, channel_up_1, Error_Counter_0
    );
endinterface

// File: rtl/channel_tester_core.sv
// Two-lane serial loopback tester: comma-framed counter pattern out, align/lock/check in.
// TX: 1 bit per clock, registered. RX: lock ~34 clocks after release; no backpressure.
module ctc_lane #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         COMMA_WORDS = 16,
    parameter int         LOCK_COUNT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxp,
    output logic       txp,
    output logic       txn,
    output logic       channel_up,
    output logic [3:0] err_cnt
);
    localparam int WCW = $clog2(COMMA_WORDS + 1);
    localparam int CCW = $clog2(LOCK_COUNT + 1);

    typedef enum logic       {SEND_COMMA, SEND_DATA} tx_state_t;
    typedef enum logic [1:0] {HUNT, LOCKING, UP}     rx_state_t;

    tx_state_t      tx_state, tx_state_nxt;
    logic [2:0]     bit_cnt;
    logic [WCW-1:0] word_cnt;
    logic [7:0]     data_cnt, tx_word;
    logic           tx_bit, word_end;

    always_comb begin
        tx_state_nxt = tx_state;
        word_end     = (bit_cnt == 3'd7);
        tx_word      = (tx_state == SEND_DATA) ? data_cnt : COMMA;
        if (tx_state == SEND_COMMA && word_end && word_cnt == WCW'(COMMA_WORDS - 1))
            tx_state_nxt = SEND_DATA;
        tx_bit = tx_word[3'd7 - bit_cnt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= SEND_COMMA;
            bit_cnt  <= 3'd0;
            word_cnt <= '0;
            data_cnt <= 8'd0;
            txp      <= 1'b0;
        end else begin
            txp      <= tx_bit;
            bit_cnt  <= bit_cnt + 3'd1;
            tx_state <= tx_state_nxt;
            if (word_end) begin
                if (tx_state == SEND_COMMA) word_cnt <= word_cnt + 1'b1;
                else                        data_cnt <= data_cnt + 8'd1;
            end
        end
    end

    assign txn = ~txp;

    rx_state_t      rx_state, rx_state_nxt;
    logic [7:0]     rx_sr, exp_dat;
    logic [2:0]     rx_ph;
    logic [CCW-1:0] comma_cnt, comma_cnt_nxt;
    logic           data_seen, ph_clr, chk_word, at_bound, is_comma;

    always_comb begin
        rx_state_nxt  = rx_state;
        comma_cnt_nxt = comma_cnt;
        ph_clr        = 1'b0;
        chk_word      = 1'b0;
        at_bound      = (rx_ph == 3'd7);
        is_comma      = (rx_sr == COMMA);
        case (rx_state)
            HUNT: begin
                if (is_comma) begin
                    ph_clr        = 1'b1;
                    comma_cnt_nxt = CCW'(1);
                    rx_state_nxt  = (LOCK_COUNT <= 1) ? UP : LOCKING;
                end
            end
            LOCKING: begin
                if (at_bound) begin
                    if (is_comma) begin
                        comma_cnt_nxt = comma_cnt + 1'b1;
                        if (comma_cnt_nxt == CCW'(LOCK_COUNT)) rx_state_nxt = UP;
                    end else begin
                        comma_cnt_nxt = '0;
                        rx_state_nxt  = HUNT;
                    end
                end
            end
            // Commas are skipped only until the first data word, so a counter value
            // equal to the comma later on is still checked.
            UP:      chk_word = at_bound && (data_seen || !is_comma);
            default: rx_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr     <= 8'd0;
            rx_ph     <= 3'd0;
            rx_state  <= HUNT;
            comma_cnt <= '0;
            data_seen <= 1'b0;
            exp_dat   <= 8'd0;
            err_cnt   <= 4'd0;
        end else begin
            rx_sr     <= {rx_sr[6:0], rxp};
            rx_ph     <= ph_clr ? 3'd0 : rx_ph + 3'd1;
            rx_state  <= rx_state_nxt;
            comma_cnt <= comma_cnt_nxt;
            if (chk_word) begin
                data_seen <= 1'b1;
                exp_dat   <= exp_dat + 8'd1;
                if (rx_sr != exp_dat && err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
            end
        end
    end

    assign channel_up = (rx_state == UP);
endmodule

module channel_tester_core #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         COMMA_WORDS = 16,
    parameter int         LOCK_COUNT  = 4
) (
    input  logic                        clk_200MHz_p,
    input  logic                        clk_200MHz_n,
    input  logic                        peripheral_reset,
    channel_tester_core_if.slave        link
);
    logic       txp_0, txn_0, txp_1, txn_1, up_0, up_1;
    logic [3:0] err_0, err_1;

    ctc_lane #(.COMMA(COMMA), .COMMA_WORDS(COMMA_WORDS), .LOCK_COUNT(LOCK_COUNT)) u_lane_0 (
        .clk(clk_200MHz_p), .rst_n(peripheral_reset), .rxp(link.rxp_0),
        .txp(txp_0), .txn(txn_0), .channel_up(up_0), .err_cnt(err_0)
    );

    // Lane 1 error count stays internal.
    ctc_lane #(.COMMA(COMMA), .COMMA_WORDS(COMMA_WORDS), .LOCK_COUNT(LOCK_COUNT)) u_lane_1 (
        .clk(clk_200MHz_p), .rst_n(peripheral_reset), .rxp(link.rxp_1),
        .txp(txp_1), .txn(txn_1), .channel_up(up_1), .err_cnt(err_1)
    );

    assign link.txp_0           = txp_0;
    assign link.txn_0           = txn_0;
    assign link.txp_1           = txp_1;
    assign link.txn_1           = txn_1;
    assign link.channel_up_0    = up_0;
    assign link.channel_up_1    = up_1;
    assign link.Error_Counter_0 = err_0;
endmodule

// File: tb/tb_channel_tester_core.sv
// Loopback bench for channel_tester_core with randomized bit-flip injection and a stream-level reference model.
`timescale 1ns/100ps
module tb_channel_tester_core;
    logic clk_p = 1'b0;
    logic clk_n;
    logic rst_n = 1'b0;
    logic flip0 = 1'b0, flip1 = 1'b0, tie0 = 1'b0;
    int   n_checks = 0, n_fail = 0, ecount = 0;
    int   bad_words[$];

    channel_tester_core_if link();

    always #2.5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    assign link.rxp_0 = tie0 ? 1'b0 : (link.txp_0 ^ flip0);
    assign link.rxn_0 = ~link.rxp_0;
    assign link.rxp_1 = link.txp_1 ^ flip1;
    assign link.rxn_1 = ~link.rxp_1;

    channel_tester_core dut (
        .clk_200MHz_p    (clk_p),
        .clk_200MHz_n    (clk_n),
        .peripheral_reset(rst_n),
        .link            (link)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, ecount);
        end
    endtask

    // Bit n of the transmitted stream: 16 commas, then an 8-bit counter, MSB first.
    function automatic logic tx_model(input int n);
        int         w;
        logic [7:0] word;
        w    = n / 8;
        word = (w < 16) ? 8'hBC : 8'((w - 16) % 256);
        return word[7 - (n % 8)];
    endfunction

    // Word w's last bit is on txp after edge 8w+8, captured at 8w+9, counted at 8w+10.
    function automatic int err_model(input int e);
        int c = 0;
        foreach (bad_words[i]) if (8 * bad_words[i] + 10 <= e) c++;
        return (c > 15) ? 15 : c;
    endfunction

    task automatic tick();
        logic b, nb;
        @(posedge clk_p);
        #1;
        ecount++;
        b  = tx_model(ecount - 1);
        nb = ~b;
        chk("txp_0", link.txp_0, b);
        chk("txn_0", link.txn_0, nb);
        chk("txp_1", link.txp_1, b);
        chk("txn_1", link.txn_1, nb);
        chk("err_cnt", link.Error_Counter_0, err_model(ecount));
        if (ecount >= 40) begin
            chk("up_1", link.channel_up_1, 1);
            chk("up_0", link.channel_up_0, tie0 ? 0 : 1);
        end else if (tie0) begin
            chk("up_0_tied", link.channel_up_0, 0);
        end
    endtask

    task automatic release_rst();
        @(negedge clk_p);
        rst_n  = 1'b1;
        ecount = 0;
    endtask

    task automatic flip_lane0();
        flip0 = 1'b1;
        bad_words.push_back((ecount - 1) / 8);
        tick();
        flip0 = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_txp_0"}, link.txp_0, 0);
        chk({tag, "_txn_0"}, link.txn_0, 1);
        chk({tag, "_txp_1"}, link.txp_1, 0);
        chk({tag, "_txn_1"}, link.txn_1, 1);
        chk({tag, "_up_0"}, link.channel_up_0, 0);
        chk({tag, "_up_1"}, link.channel_up_1, 0);
        chk({tag, "_err"}, link.Error_Counter_0, 0);
    endtask

    initial begin
        #1000;
        chk_reset_vals("rst");
        release_rst();
        repeat (40) tick();
        chk("lock_up_0", link.channel_up_0, 1);
        chk("lock_up_1", link.channel_up_1, 1);
        while (ecount < 5000) tick();
        chk("clean_err", link.Error_Counter_0, 0);

        // Lane 1 corruption must not reach the exported counter.
        repeat ($urandom_range(0, 15)) tick();
        flip1 = 1'b1;
        tick();
        flip1 = 1'b0;
        repeat (100) tick();
        chk("lane1_err", link.Error_Counter_0, 0);
        chk("lane1_up", link.channel_up_1, 1);

        // Single lane 0 bit error costs exactly one count.
        repeat ($urandom_range(0, 15)) tick();
        flip_lane0();
        repeat (40) tick();
        chk("single_err", link.Error_Counter_0, 1);
        repeat (300) tick();
        chk("single_err_hold", link.Error_Counter_0, 1);

        // 19 more corrupted words (20 total) saturate the counter.
        for (int i = 0; i < 19; i++) begin
            flip_lane0();
            repeat (8 + $urandom_range(0, 15)) tick();
        end
        repeat (20) tick();
        chk("err_sat", link.Error_Counter_0, 15);

        // Asynchronous reset mid-data takes effect without a clock edge.
        #1;
        rst_n = 1'b0;
        bad_words.delete();
        #1;
        chk_reset_vals("midrst");
        repeat (5) @(posedge clk_p);
        release_rst();
        repeat (40) tick();
        chk("relock_up_0", link.channel_up_0, 1);
        chk("relock_up_1", link.channel_up_1, 1);
        chk("relock_err", link.Error_Counter_0, 0);
        repeat (300) tick();

        // Lane 0 receive tied low: never locks, lane 1 unaffected.
        rst_n = 1'b0;
        tie0  = 1'b1;
        repeat (3) @(posedge clk_p);
        release_rst();
        repeat (500) tick();
        chk("tie_up_0", link.channel_up_0, 0);
        chk("tie_up_1", link.channel_up_1, 1);
        chk("tie_err", link.Error_Counter_0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
